// File: rtl/serial_2wire_target_if.sv
// Purpose : parallel-side word interface of the 2-wire serial target.
// Latency : none; plain signal bundle.
// Backpressure: none. The controller paces every word, and the user must keep up with the request pulses.
//
// Ports (signals):
//   in_parallel      user -> target, the word to send in read mode
//   out_parallel     target -> user, the last word received in write mode
//   out_word_valid   target -> user, 1-cycle pulse when out_parallel updates
//   out_word_request target -> user, 1-cycle pulse when in_parallel was latched
//   out_busy         target -> user, a valid address was acked and no START/STOP followed
//   out_write        target -> user, 1 = write mode, 0 = read mode (valid while busy)
interface serial_2wire_target_if #(
    parameter int BITS = 8
) ();
    logic [BITS-1:0] in_parallel;
    logic [BITS-1:0] out_parallel;
    logic            out_word_valid;
    logic            out_word_request;
    logic            out_busy;
    logic            out_write;

    // Target side.
    modport slave (
        input  in_parallel,
        output out_parallel,
        output out_word_valid,
        output out_word_request,
        output out_busy,
        output out_write
    );

    // User / application side.
    modport master (
        output in_parallel,
        input  out_parallel,
        input  out_word_valid,
        input  out_word_request,
        input  out_busy,
        input  out_write
    );
endinterface

// File: rtl/serial_2wire_target.sv
// Purpose : 2-wire (open-drain SDA, controller-driven SCL) serial target with one write and one read address.
// Latency : acts 3 in_clk cycles after a serial edge, made up of 2 synchroniser stages and 1 state register.
// Backpressure: none. The controller paces all transfers, and in_parallel must be stable before the latching scl_fall.
//
// Ports:
//   in_clk, in_rst   main clock and synchronous active-high reset
//   in_serial_clk    SCL from the controller (input only)
//   inout_serial     SDA, driven only to 0 or released to z
//   word_if          parallel word interface (slave modport)
module serial_2wire_target #(
    parameter int                   ADDR_BITS    = 8,
    parameter int                   BITS         = 8,
    parameter logic                 LOWBIT_FIRST = 1'b1,
    parameter logic [ADDR_BITS-1:0] ADDR_WRITE   = 8'h90,
    parameter logic [ADDR_BITS-1:0] ADDR_READ    = 8'h91
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_serial_clk,
    inout  wire                   inout_serial,
    serial_2wire_target_if.slave  word_if
);

    localparam int MAXB = (ADDR_BITS > BITS) ? ADDR_BITS : BITS;
    localparam int IW   = $clog2(MAXB);
    localparam int CW   = IW + 1;

    localparam logic [CW-1:0] ADDR_N    = CW'(ADDR_BITS);
    localparam logic [CW-1:0] DATA_N    = CW'(BITS);
    localparam logic [IW-1:0] ADDR_LAST = IW'(ADDR_BITS - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RECV_ADDR = 3'd1;
    localparam logic [2:0] ST_ACK_ADDR  = 3'd2;
    localparam logic [2:0] ST_RECV_DATA = 3'd3;
    localparam logic [2:0] ST_ACK_DATA  = 3'd4;
    localparam logic [2:0] ST_SEND_DATA = 3'd5;
    localparam logic [2:0] ST_RECV_ACK  = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    // Synchronisers. The *_p_q registers hold the previous synchronised value, which is used for edge detection.
    logic scl_m_q, scl_s_q, scl_p_q;
    logic sda_m_q, sda_s_q, sda_p_q;

    logic [2:0]      state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [MAXB-1:0] shreg_q,   shreg_d;
    logic [BITS-1:0] tx_q,      tx_d;
    logic            ack_smp_q, ack_smp_d;
    logic            sda_low_q, sda_low_d;
    logic [BITS-1:0] par_q,     par_d;
    logic            vld_q,     vld_d;
    logic            req_q,     req_d;
    logic            busy_q,    busy_d;
    logic            write_q,   write_d;

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s_q & ~scl_p_q;
    assign scl_fall  = ~scl_s_q &  scl_p_q;
    assign start_det =  sda_p_q & ~sda_s_q & scl_s_q;
    assign stop_det  = ~sda_p_q &  sda_s_q & scl_s_q;

    // Bit position for the current count. The address and data words can differ in length, so MSB-first needs the right top index.
    logic [IW-1:0] rx_idx, tx_idx;
    logic          first_bit;
    assign rx_idx    = LOWBIT_FIRST ? cnt_q[IW-1:0]
                     : (((state_q == ST_RECV_ADDR) ? ADDR_LAST : DATA_LAST) - cnt_q[IW-1:0]);
    assign tx_idx    = LOWBIT_FIRST ? cnt_q[IW-1:0] : (DATA_LAST - cnt_q[IW-1:0]);
    assign first_bit = LOWBIT_FIRST ? word_if.in_parallel[0] : word_if.in_parallel[BITS-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        ack_smp_d = ack_smp_q;
        sda_low_d = sda_low_q;
        par_d     = par_q;
        vld_d     = 1'b0;
        req_d     = 1'b0;
        busy_d    = busy_q;
        write_d   = write_q;

        // Bus conditions override any scl edge seen in the same cycle.
        if (start_det) begin
            state_d   = ST_RECV_ADDR;
            cnt_d     = '0;
            shreg_d   = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RECV_ADDR: begin
                    if (scl_rise && (cnt_q < ADDR_N)) begin
                        shreg_d[rx_idx] = sda_s_q;
                        cnt_d           = cnt_q + 1'b1;
                    end else if (scl_fall && (cnt_q == ADDR_N)) begin
                        cnt_d = '0;
                        if (shreg_q[ADDR_BITS-1:0] == ADDR_WRITE) begin
                            sda_low_d = 1'b1;
                            write_d   = 1'b1;
                            state_d   = ST_ACK_ADDR;
                        end else if (shreg_q[ADDR_BITS-1:0] == ADDR_READ) begin
                            sda_low_d = 1'b1;
                            write_d   = 1'b0;
                            state_d   = ST_ACK_ADDR;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        busy_d = 1'b1;
                        if (write_q) begin
                            sda_low_d = 1'b0;
                            cnt_d     = '0;
                            shreg_d   = '0;
                            state_d   = ST_RECV_DATA;
                        end else begin
                            tx_d      = word_if.in_parallel;
                            req_d     = 1'b1;
                            sda_low_d = ~first_bit;
                            cnt_d     = CW'(1);
                            state_d   = ST_SEND_DATA;
                        end
                    end
                end
                ST_RECV_DATA: begin
                    if (scl_rise && (cnt_q < DATA_N)) begin
                        shreg_d[rx_idx] = sda_s_q;
                        cnt_d           = cnt_q + 1'b1;
                    end else if (scl_fall && (cnt_q == DATA_N)) begin
                        sda_low_d = 1'b1;
                        par_d     = shreg_q[BITS-1:0];
                        vld_d     = 1'b1;
                        state_d   = ST_ACK_DATA;
                    end
                end
                ST_ACK_DATA: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        cnt_d     = '0;
                        shreg_d   = '0;
                        state_d   = ST_RECV_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    // cnt counts bits already placed on the bus. The fall that ends the last bit hands SDA to the controller.
                    if (scl_fall) begin
                        if (cnt_q < DATA_N) begin
                            sda_low_d = ~tx_q[tx_idx];
                            cnt_d     = cnt_q + 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_RECV_ACK;
                        end
                    end
                end
                ST_RECV_ACK: begin
                    // A non-zero cnt marks that the ack bit has been sampled. A fall without a preceding rise is ignored.
                    if (scl_rise) begin
                        ack_smp_d = sda_s_q;
                        cnt_d     = CW'(1);
                    end else if (scl_fall && (cnt_q != '0)) begin
                        if (!ack_smp_q) begin
                            tx_d      = word_if.in_parallel;
                            req_d     = 1'b1;
                            sda_low_d = ~first_bit;
                            cnt_d     = CW'(1);
                            state_d   = ST_SEND_DATA;
                        end else begin
                            sda_low_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_WAIT_STOP;
                        end
                    end
                end
                default: begin
                    // Idle / WaitStop: bus released, scl ignored.
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            scl_m_q   <= 1'b0;
            scl_s_q   <= 1'b0;
            scl_p_q   <= 1'b0;
            sda_m_q   <= 1'b0;
            sda_s_q   <= 1'b0;
            sda_p_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            tx_q      <= '0;
            ack_smp_q <= 1'b0;
            sda_low_q <= 1'b0;
            par_q     <= '0;
            vld_q     <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            scl_m_q   <= in_serial_clk;
            scl_s_q   <= scl_m_q;
            scl_p_q   <= scl_s_q;
            sda_m_q   <= inout_serial;
            sda_s_q   <= sda_m_q;
            sda_p_q   <= sda_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            ack_smp_q <= ack_smp_d;
            sda_low_q <= sda_low_d;
            par_q     <= par_d;
            vld_q     <= vld_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
        end
    end

    assign inout_serial             = sda_low_q ? 1'b0 : 1'bz;
    assign word_if.out_parallel     = par_q;
    assign word_if.out_word_valid   = vld_q;
    assign word_if.out_word_request = req_q;
    assign word_if.out_busy         = busy_q;
    assign word_if.out_write        = write_q;

endmodule

// File: doc/serial_2wire_target.md
SERIAL_2WIRE_TARGET -- requirements
Module: serial_2wire_target

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, meaning address word length in bits.
REQ-002 The block SHALL have parameter BITS, default 8, meaning data word length in bits.
REQ-003 The block SHALL have parameter LOWBIT_FIRST, default 1'b1, meaning bit 0 is transferred first when 1 and bit BITS-1 first when 0.
REQ-004 The block SHALL have parameter ADDR_WRITE, default 8'h90, meaning the address that selects write mode (controller -> target).
REQ-005 The block SHALL have parameter ADDR_READ, default 8'h91, meaning the address that selects read mode (target -> controller).
REQ-006 The block SHALL have port in_clk, input, 1 bit, main clock; it is the only clock, and all logic is clocked on its rising edge.
REQ-007 The block SHALL have port in_rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-008 The block SHALL have port in_serial_clk, input, 1 bit, the serial clock from the controller; the target never drives it.
REQ-009 The block SHALL have port inout_serial, inout, 1 bit, open-drain serial data; it is driven only to 0 or z.
REQ-010 The block SHALL have port in_parallel, input, BITS bits, the word to send in read mode.
REQ-011 The block SHALL have port out_parallel, output, BITS bits, the last word received in write mode.
REQ-012 The block SHALL have port out_word_valid, output, 1 bit, a 1-cycle pulse when out_parallel is updated.
REQ-013 The block SHALL have port out_word_request, output, 1 bit, a 1-cycle pulse when in_parallel has been latched, so the next word may be applied.
REQ-014 The block SHALL have port out_busy, output, 1 bit, high when a valid address has been acknowledged and no STOP or START has followed yet.
REQ-015 The block SHALL have port out_write, output, 1 bit, 1 in write mode and 0 in read mode; it is meaningful only while out_busy=1.

Function
REQ-016 The block SHALL synchronise in_serial_clk and inout_serial through 2 flip-flops each, and use only the synchronised values (scl_s, sda_s) for all decisions.
REQ-017 The block SHALL define the following edge events, each detected from the current and previous scl_s/sda_s values and each lasting one cycle:
- scl_rise: scl_s goes 0 -> 1.
- scl_fall: scl_s goes 1 -> 0.
- START: sda_s goes 1 -> 0 while scl_s = 1.
- STOP: sda_s goes 0 -> 1 while scl_s = 1.
REQ-018 The block SHALL implement the states Idle, RecvAddr, AckAddr, RecvData, AckData, SendData, RecvAck and WaitStop.
REQ-019 START SHALL move the block from any state to RecvAddr, clear the bit counter, clear the shift register and release SDA (this covers repeated START).
REQ-020 STOP SHALL move the block from any state to Idle, release SDA and clear out_busy.
REQ-021 START/STOP detection SHALL take priority over scl edges in the same cycle.
REQ-022 In RecvAddr, each scl_rise SHALL store sda_s at index actual_bit (which honours LOWBIT_FIRST), and the counter SHALL increment.
REQ-023 After the ADDR_BITS-th bit is stored, the address SHALL be handled on the next scl_fall:
- address = ADDR_WRITE: drive SDA=0, go to AckAddr, set out_write=1.
- address = ADDR_READ: drive SDA=0, go to AckAddr, set out_write=0.
- any other address: go to WaitStop with SDA released (NACK).
REQ-024 In AckAddr, at the following scl_fall the block SHALL:
- set out_busy=1;
- in write mode, release SDA and go to RecvData;
- in read mode, latch in_parallel, pulse out_word_request, drive the first bit and go to SendData.
REQ-025 In RecvData, each scl_rise SHALL store one bit; after BITS bits, the block SHALL drive SDA=0 at the next scl_fall, load out_parallel, pulse out_word_valid in that same cycle, and go to AckData.
REQ-026 In AckData, at scl_fall the block SHALL release SDA and return to RecvData with the counter at 0.
REQ-027 In SendData, each scl_fall SHALL drive the next bit; after the BITS-th bit's clock period, the next scl_fall SHALL release SDA and go to RecvAck.
REQ-028 In RecvAck, scl_rise SHALL sample sda_s, and the following scl_fall SHALL act on the sample:
- sample = 0 (ACK): latch in_parallel, pulse out_word_request, drive the first bit, go to SendData.
- sample = 1 (NACK): release SDA, go to WaitStop.
REQ-029 In Idle and WaitStop, SDA SHALL be released and scl edges SHALL be ignored.
REQ-030 The bit counter SHALL be $clog2(max(ADDR_BITS,BITS))+1 bits wide, and SHALL never exceed its terminal value.

Reset
REQ-031 While in_rst=1 at a clock edge, the block SHALL enter Idle, release SDA, clear the counters and the synchroniser history, and set out_parallel=0, out_word_valid=0, out_word_request=0, out_busy=0 and out_write=0.
REQ-032 A reset asserted mid-transfer SHALL abort the transfer with no output pulses, and the block SHALL wait for a fresh START afterwards.

Verification
REQ-033 Write transfer, LOWBIT_FIRST=1: START, address 8'h90, word 8'hA5, STOP -> ACK driven low on both ack clocks; out_parallel=8'hA5; exactly one out_word_valid pulse; out_busy falls at STOP.
REQ-034 Read transfer: START, 8'h91, in_parallel=8'h3C, controller ACK, then in_parallel=8'hC3, controller NACK, STOP -> bus carries 8'h3C then 8'hC3; exactly two out_word_request pulses; SDA released after the NACK.
REQ-035 Wrong address: START, 8'h55, eight more clocks -> SDA never driven low; out_busy stays 0; no output pulses.
REQ-036 Write then read: write 8'h90 and 8'h12, repeated START, then 8'h91 -> out_write goes 1 -> 0 and the read proceeds without any STOP.
REQ-037 LOWBIT_FIRST=0: write 8'h81 sent MSB first -> out_parallel=8'h81.
REQ-038 in_rst pulsed during bit 4 of a data word -> all outputs return to their reset values; a following complete write of 8'h7E succeeds.
